vga_scanout: RTL and testbench
==============================

# vga_scanout

Raster scanout engine for the 320×240 RGB565 frame buffer. It generates 640×480@60 Hz VGA timing from a 25 MHz pixel clock and fetches pixels through the video-side (port 2) read interface of the VRAM, line- and pixel-doubling each stored pixel to 2×2 screen pixels. It drives the DAC/connector pins directly and raises a vertical-blank pulse for the CPU side.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- FB_WIDTH, 320, stored pixels per frame-buffer row

Ports:
- clk  in  1  pixel clock, 25 MHz; also clocks VRAM port 2
- rst_n  in  1  asynchronous, active-low reset
- display_en  in  1  when 0, RGB forced to 0; timing keeps running
- vram_addr  out  17  frame-buffer word address to VRAM port 2
- vram_data  in  16  VRAM port 2 read data, RGB565, valid one clock after vram_addr
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  data enable, high during visible pixels
- red  out  5  pixel red (vram_data[15:11])
- green  out  6  pixel green (vram_data[10:5])
- blue  out  5  pixel blue (vram_data[4:0])
- vblank_pulse  out  1  one-clock pulse at start of vertical blank

## Operation
- Counters: h_cnt 0..799 (H_TOTAL = sum of H_*), increments every clock, wraps to 0; v_cnt 0..524 increments when h_cnt wraps, wraps to 0 after 524.
- Visible when h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
- Sync: hsync active for h_cnt in [656, 751]; vsync active for v_cnt in [490, 491] (whole lines, independent of h_cnt).
- Address: vram_addr = (v_cnt>>1)·FB_WIDTH + (h_cnt>>1), computed as ((v>>1)<<8) + ((v>>1)<<6) + (h>>1); no multiplier. Range 0..76799, always fits 17 bits. Updated only when visible; held at last value during blanking.
- Pipeline, 3 stages: S0 counters; S1 registers vram_addr plus visible/hsync/vsync flags; S2 is the VRAM read (flags delayed one more register); S3 registers all outputs.
- S3: de = visible flag; {red, green, blue} = (visible & display_en) ? vram_data : 0; hsync_n/vsync_n = inverted sync flags.
- display_en is sampled at S3, so changes take effect on the next output pixel, mid-line allowed.
- vblank_pulse: high for exactly one clock when S3 represents (h=0, v=480).
- No write path; VRAM port 2 write enable is tied low at top level.

## Timing
- Reset (asynchronous assert, synchronous release): h_cnt=0, v_cnt=0, vram_addr=0, all pipeline flags cleared, hsync_n=1, vsync_n=1, de=0, RGB=0, vblank_pulse=0.
- Latency: all outputs lag counters by exactly 3 clocks; syncs, de and RGB stay mutually aligned.
- First visible output: counters at (0,0) in cycle 0 after release; de=1 with pixel from address 0 after 3rd rising edge.
- Line period 800 clocks; frame period 420 000 clocks; hsync_n low 96 clocks per line; vsync_n low 1600 clocks per frame.
- Each VRAM word is presented on 2 consecutive clocks and on 2 consecutive lines.
- Reset mid-frame: outputs return to reset values immediately; pipeline flushed, no stale pixel emitted after release; timing restarts at (0,0).
- No back-pressure; the VRAM port 2 is owned exclusively by this block.

## Test plan
- Release reset with a VRAM model returning the address as data -> de rises at clock 3; first 4 output pixels carry 0,0,1,1; RGB=0 whenever de=0.
- Sample counters at (2,2), (639,479), (638,1) -> vram_addr 321, 76799, 319 one clock later; vram_addr never exceeds 76799 over a full frame.
- Run 2 frames -> hsync_n low for clocks 656..751 of each 800-clock line (output-referenced); vsync_n low on lines 490–491; 420 000 clocks between vsync falling edges; vblank_pulse once per frame, aligned with output (0,480).
- Drop display_en for 100 clocks mid-line -> RGB=0 for exactly those pixels, delayed 3 clocks after the change; de, hsync_n and vsync_n unaffected.
- Assert rst_n low at v=300, h=400 for 5 clocks -> outputs at reset values within the same cycle; after release, first de high at clock 3 with address 0 data.
- Fill VRAM with a checkerboard -> every stored pixel appears as a 2×2 block; pixel-count checker sees 640×480 de-high clocks per frame.

Source files
------------

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Raster scanout engine for a 320x240 RGB565 frame buffer. It generates
// 640x480@60 Hz VGA timing from a 25 MHz pixel clock. Pixels are fetched
// through the read-only video port (port 2) of the VRAM. Each stored pixel
// is doubled horizontally and vertically, so it covers a 2x2 block of
// screen pixels. The block drives the DAC/connector pins directly and raises
// a one-clock vertical-blank pulse for the CPU side. The VRAM port 2 write
// enable is tied low at the top level; this block never writes.
//
// Pipeline:
//   S0  h/v raster counters
//   S1  vram_addr register, plus the visible/hsync/vsync/vblank flags
//   S2  VRAM read cycle (the flags wait one more register)
//   S3  output registers
// All outputs lag the counters by exactly three clocks and stay mutually
// aligned.
//
// rst_n asserts asynchronously. Its release is expected to be synchronous
// to clk, and is synchronised upstream.
//
// Ports:
//   clk           in   1   pixel clock (25 MHz); also clocks VRAM port 2
//   rst_n         in   1   asynchronous active-low reset
//   display_en    in   1   0 forces RGB to zero; the timing keeps running
//   vram_addr     out  17  frame-buffer word address to VRAM port 2
//   vram_data     in   16  VRAM port 2 read data (RGB565), one clock after addr
//   hsync_n       out  1   horizontal sync, active low
//   vsync_n       out  1   vertical sync, active low
//   de            out  1   data enable, high during visible pixels
//   red           out  5   pixel red   (vram_data[15:11])
//   green         out  6   pixel green (vram_data[10:5])
//   blue          out  5   pixel blue  (vram_data[4:0])
//   vblank_pulse  out  1   one-clock pulse at the start of vertical blank
// -----------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = 320
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        display_en,
  output logic [16:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        vblank_pulse
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS    = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0] H_HS_BEG = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0] H_HS_END = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);

  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0] V_VS_BEG = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0] V_VS_END = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Frame-buffer word address for raster position (h, v), with 2x2 pixel
  // doubling. For the native 320-word row the multiply is replaced by
  // row*256 + row*64. The sum peaks at 76799, so 17 bits never overflow.
  function automatic logic [16:0] fb_addr(input logic [V_W-1:0] v,
                                          input logic [H_W-1:0] h);
    logic [16:0] row;
    logic [16:0] col;
    row = 17'(v >> 1);
    col = 17'(h >> 1);
    if (FB_WIDTH == 320)
      return (row << 8) + (row << 6) + col;
    else
      return 17'(row * 17'(FB_WIDTH)) + col;
  endfunction

  // ---------------------------------------------------------------------------
  // S0: raster counters
  // ---------------------------------------------------------------------------
  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  logic        w_vld_p0;
  logic        w_hs_p0;
  logic        w_vs_p0;
  logic        w_vbl_p0;
  logic [16:0] w_addr_p0;

  always_comb begin
    w_vld_p0  = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hs_p0   = (r_h_cnt >= H_HS_BEG) && (r_h_cnt <= H_HS_END);
    // vsync covers whole lines, regardless of the horizontal position.
    w_vs_p0   = (r_v_cnt >= V_VS_BEG) && (r_v_cnt <= V_VS_END);
    w_vbl_p0  = (r_h_cnt == '0) && (r_v_cnt == V_VIS);
    w_addr_p0 = fb_addr(r_v_cnt, r_h_cnt);
  end

  // ---------------------------------------------------------------------------
  // S1: VRAM address and timing flags
  // ---------------------------------------------------------------------------
  logic [16:0] r_addr_p1;
  logic        r_vld_p1;
  logic        r_hs_p1;
  logic        r_vs_p1;
  logic        r_vbl_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_hs_p1   <= 1'b0;
      r_vs_p1   <= 1'b0;
      r_vbl_p1  <= 1'b0;
    end else begin
      // During blanking the address holds its last value. This keeps the
      // VRAM port quiet and bounds the address to the visible range.
      if (w_vld_p0)
        r_addr_p1 <= w_addr_p0;
      r_vld_p1 <= w_vld_p0;
      r_hs_p1  <= w_hs_p0;
      r_vs_p1  <= w_vs_p0;
      r_vbl_p1 <= w_vbl_p0;
    end
  end

  assign vram_addr = r_addr_p1;

  // ---------------------------------------------------------------------------
  // S2: VRAM read in flight; flags wait one register for the data
  // ---------------------------------------------------------------------------
  logic r_vld_p2;
  logic r_hs_p2;
  logic r_vs_p2;
  logic r_vbl_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_hs_p2  <= 1'b0;
      r_vs_p2  <= 1'b0;
      r_vbl_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_vbl_p2 <= r_vbl_p1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: output registers
  // ---------------------------------------------------------------------------
  logic        r_de_p3;
  logic        r_hsync_n_p3;
  logic        r_vsync_n_p3;
  logic        r_vbl_p3;
  logic [15:0] r_rgb_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_p3      <= 1'b0;
      r_hsync_n_p3 <= 1'b1;
      r_vsync_n_p3 <= 1'b1;
      r_vbl_p3     <= 1'b0;
      r_rgb_p3     <= '0;
    end else begin
      r_de_p3      <= r_vld_p2;
      r_hsync_n_p3 <= ~r_hs_p2;
      r_vsync_n_p3 <= ~r_vs_p2;
      r_vbl_p3     <= r_vbl_p2;
      // display_en is sampled here, not at S0, so that blanking takes
      // effect on the very next output pixel, even in mid-line.
      r_rgb_p3     <= (r_vld_p2 && display_en) ? vram_data : '0;
    end
  end

  assign de           = r_de_p3;
  assign hsync_n      = r_hsync_n_p3;
  assign vsync_n      = r_vsync_n_p3;
  assign vblank_pulse = r_vbl_p3;
  assign red          = r_rgb_p3[15:11];
  assign green        = r_rgb_p3[10:5];
  assign blue         = r_rgb_p3[4:0];

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// Directed bench with two instances of vga_scanout:
//   u_a: default 640x480 timing. Covers reset, the first pixels, address
//        spot values and a mid-line display_en drop.
//   u_b: shrunken 16x8 raster (24-clock lines, 12-line frames). Covers
//        whole-frame sync, vblank and pixel counts, and a mid-frame reset.
// A VRAM model per instance returns data one clock after the address. The
// data is either the address itself or a 2x2-pixel checkerboard.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst_a, rst_b, en_a, en_b;
  logic [16:0] addr_a, addr_b;
  logic [15:0] vd_a, vd_b;
  logic        hs_a, vs_a, de_a, vbl_a;
  logic        hs_b, vs_b, de_b, vbl_b;
  logic [4:0]  r_a, b_a, r_b, b_b;
  logic [5:0]  g_a, g_b;

  vga_scanout u_a (
    .clk(clk), .rst_n(rst_a), .display_en(en_a), .vram_addr(addr_a),
    .vram_data(vd_a), .hsync_n(hs_a), .vsync_n(vs_a), .de(de_a),
    .red(r_a), .green(g_a), .blue(b_a), .vblank_pulse(vbl_a)
  );

  vga_scanout #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .FB_WIDTH(320)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .display_en(en_b), .vram_addr(addr_b),
    .vram_data(vd_b), .hsync_n(hs_b), .vsync_n(vs_b), .de(de_b),
    .red(r_b), .green(g_b), .blue(b_b), .vblank_pulse(vbl_b)
  );

  // Raster parameters of the two instances: index 0 = u_a, 1 = u_b.
  int HV[2] = '{640, 16};
  int HF[2] = '{16, 2};
  int HS[2] = '{96, 3};
  int HB[2] = '{48, 3};
  int VV[2] = '{480, 8};
  int VF[2] = '{10, 1};
  int VS[2] = '{2, 2};
  int VB[2] = '{33, 1};

  bit mode; // 0: data = address, 1: checkerboard of 2x2 blocks

  int total = 0;
  int bad   = 0;

  // Bench model state per instance.
  int          k[2];        // rising edges since reset release
  logic [16:0] eaddr[2];    // expected vram_addr
  bit          en_used[2];  // display_en seen at the most recent edge

  // u_b frame statistics.
  int de_cnt, hs_low, vs_low, vbl_cnt, last_fall;
  bit prev_vs;

  localparam logic [36:0] RST_PK = {4'b0110, 16'h0000, 17'h0};

  logic [36:0] pk_a, pk_b;
  assign pk_a = {de_a, hs_a, vs_a, vbl_a, r_a, g_a, b_a, addr_a};
  assign pk_b = {de_b, hs_b, vs_b, vbl_b, r_b, g_b, b_b, addr_b};

  function automatic logic [15:0] mem(input logic [16:0] a);
    int ai, x, y;
    ai = int'(a);
    if (!mode) return a[15:0];
    x = ai % 320;
    y = ai / 320;
    return (((x ^ y) & 1) != 0) ? 16'hFFFF : 16'h0000;
  endfunction

  always @(posedge clk) begin
    vd_a <= mem(addr_a);
    vd_b <= mem(addr_b);
  end

  function automatic int ht(input int w);
    return HV[w] + HF[w] + HS[w] + HB[w];
  endfunction

  function automatic int vt(input int w);
    return VV[w] + VF[w] + VS[w] + VB[w];
  endfunction

  function automatic logic [16:0] maddr(input int h, input int v);
    return 17'((v / 2) * 320 + h / 2);
  endfunction

  // Expected packed outputs after k[w] edges. The outputs show the counter
  // state three edges earlier.
  function automatic logic [36:0] model(input int w);
    int n, h, v;
    bit vis, hs, vs, vb;
    logic [15:0] px;
    if (k[w] < 3) return {4'b0110, 16'h0000, eaddr[w]};
    n   = k[w] - 3;
    h   = n % ht(w);
    v   = (n / ht(w)) % vt(w);
    vis = (h < HV[w]) && (v < VV[w]);
    hs  = (h >= HV[w] + HF[w]) && (h < HV[w] + HF[w] + HS[w]);
    vs  = (v >= VV[w] + VF[w]) && (v < VV[w] + VF[w] + VS[w]);
    vb  = (h == 0) && (v == VV[w]);
    px  = (vis && en_used[w]) ? mem(maddr(h, v)) : 16'h0000;
    return {vis, !hs, !vs, vb, px, eaddr[w]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic restart(input int w);
    k[w] = 0;
    eaddr[w] = '0;
    en_used[w] = 1'b1;
    de_cnt = 0; hs_low = 0; vs_low = 0; vbl_cnt = 0;
    last_fall = -1; prev_vs = 1'b1;
  endtask

  // Check the current outputs of instance w, then drive inputs and advance
  // one clock (ending just after the falling edge).
  task automatic step(input int w);
    int n, h, v;
    bit en_next;
    if (w == 0) begin
      chk("outA", pk_a, model(0));
      if (k[0] == 2)  chk("de_before_3", de_a, 1'b0);
      if (k[0] == 3)  chk("de_at_3", de_a, 1'b1);
      if (k[0] >= 3 && k[0] <= 6) chk("first_px", {r_a, g_a, b_a}, (k[0] - 3) / 2);
      if (k[0] == 700)  chk("addr_hold_blank", addr_a, 319);
      if (k[0] == 1439) chk("addr_638_1", addr_a, 319);
      if (k[0] == 1603) chk("addr_2_2", addr_a, 321);
      if (k[0] == 899)  chk("en_last_on_px", {r_a, g_a, b_a}, 48);
      if (k[0] == 900) begin
        chk("en_off_px", {r_a, g_a, b_a}, 0);
        chk("en_off_de", de_a, 1'b1);
      end
      if (k[0] == 999)  chk("en_last_off_px", {r_a, g_a, b_a}, 0);
      if (k[0] == 1000) chk("en_back_px", {r_a, g_a, b_a}, 98);
      // display_en low for the 100 edges 900..999 (line 1, h=97..196 out)
      en_a = !((k[0] + 1 >= 900) && (k[0] + 1 < 1000));
      en_next = en_a;
    end else begin
      chk("outB", pk_b, model(1));
      if (k[1] >= 3 && k[1] < 291) begin
        de_cnt  += int'(de_b);
        hs_low  += int'(!hs_b);
        vs_low  += int'(!vs_b);
        vbl_cnt += int'(vbl_b);
      end
      if (k[1] == 291) begin
        chk("frame_de_cnt", de_cnt, 128);
        chk("frame_hs_low", hs_low, 36);
        chk("frame_vs_low", vs_low, 48);
        chk("frame_vbl_cnt", vbl_cnt, 1);
      end
      if (prev_vs && !vs_b) begin
        if (last_fall >= 0) chk("vs_period", k[1] - last_fall, 288);
        last_fall = k[1];
      end
      prev_vs = vs_b;
      en_next = en_b;
    end
    @(negedge clk);
    n = k[w];
    h = n % ht(w);
    v = (n / ht(w)) % vt(w);
    if ((h < HV[w]) && (v < VV[w])) eaddr[w] = maddr(h, v);
    k[w]++;
    en_used[w] = en_next;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1; mode = 1'b0;
    restart(0);
    restart(1);
    repeat (3) @(negedge clk);
    chk("reset_A", pk_a, RST_PK);
    chk("reset_B", pk_b, RST_PK);

    // Default timing: first pixels, addresses, display_en drop.
    rst_a = 1'b1;
    restart(0);
    repeat (2500) step(0);

    // Shrunken raster: two frame periods' worth of sync/vblank checks.
    rst_b = 1'b1;
    restart(1);
    repeat (610) step(1);

    // Mid-frame reset while a visible, non-zero pixel is on the outputs.
    chk("pre_reset_de", de_b, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("async_reset_B", pk_b, RST_PK);
    repeat (5) begin
      @(negedge clk);
      chk("hold_reset_B", pk_b, RST_PK);
    end

    // Restart from (0,0) with a checkerboard frame buffer.
    mode = 1'b1;
    rst_b = 1'b1;
    restart(1);
    repeat (300) step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
